// File: rtl/xnorseq_pkg.sv
// Shared definitions for the sequential XNOR-popcount layer: controller state encoding and the
// per-neuron sum width helper used by the controller, the datapath and the bench.
package xnorseq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StCapture,
    StOut
  } state_e;

  // Bits needed to hold a popcount of n inputs (0..n inclusive).
  function automatic int unsigned suml(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xnorseq_thresh.sv
// Per-neuron binarizer: bits[i] = (sums[i] >= thr[i]), unsigned SumL-bit compare.
// Purely combinational; only instantiated when XNORSEQ_THRESH_EN is defined.
// Ports:
//   sums  M*SumL  popcount sums, neuron i at [i*SumL +: SumL]
//   thr   M*SumL  thresholds, same packing
//   bits  M       binarized result, neuron i at bit i
module xnorseq_thresh #(
  parameter int unsigned M    = 4,
  parameter int unsigned SumL = 3
) (
  input  logic [M*SumL-1:0] sums,
  input  logic [M*SumL-1:0] thr,
  output logic [M-1:0]      bits
);

  always_comb begin
    bits = '0;
    for (int i = 0; i < M; i++) begin
      bits[i] = (sums[i*SumL +: SumL] >= thr[i*SumL +: SumL]);
    end
  end

endmodule

// File: rtl/xnorseq_ctrl.sv
// Sequencing controller for the sequential XNOR-popcount datapath.
// Accepts one N-bit vector, clears the datapath for one cycle, enables it for LAT cycles,
// captures the M sums and presents them (optionally binarized) on a valid/ready port.
// Optional feature macro: XNORSEQ_THRESH_EN builds the threshold register and comparators;
// without it thr is ignored and out_bits is constant 0.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data   input vector handshake
//   thr                         per-neuron thresholds, sampled with the vector
//   dp_data/dp_rst/dp_enable    drive the datapath; dp_sums comes back from it
//   out_valid/out_ready         result handshake carrying out_sums and out_bits
//   busy                        controller not idle
module xnorseq_ctrl
  import xnorseq_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  int unsigned M    = 4,
  parameter  int unsigned LAT  = 4,
  localparam int unsigned SumL = suml(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  input  logic [M*SumL-1:0] thr,
  output logic [N-1:0]      dp_data,
  output logic              dp_rst,
  output logic              dp_enable,
  input  logic [M*SumL-1:0] dp_sums,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M*SumL-1:0] out_sums,
  output logic [M-1:0]      out_bits,
  output logic              busy
);

  if (LAT < 1) begin : g_bad_lat
    $error("xnorseq_ctrl: LAT must be >= 1");
  end

  localparam int unsigned     CntW    = $clog2(LAT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(LAT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]      dp_data_q;
  logic [M*SumL-1:0] out_sums_q;

  logic accept;
  logic capture;

  assign accept  = (state_q == StIdle) && in_valid;
  assign capture = (state_q == StCapture);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = StClear;
      end
      StClear: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (cnt_q == LastCnt) state_d = StCapture;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StCapture: begin
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state; rst only enters through the reset terms so the
  // datapath stays cleared and no vector is offered while the controller is held in reset.
  always_comb begin
    in_ready  = (state_q == StIdle) && rst;
    dp_rst    = !rst || (state_q == StClear);
    dp_enable = (state_q == StRun);
    out_valid = (state_q == StOut);
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_data_q  <= '0;
      out_sums_q <= '0;
    end else begin
      if (accept)  dp_data_q  <= in_data;
      if (capture) out_sums_q <= dp_sums;
    end
  end

  assign dp_data  = dp_data_q;
  assign out_sums = out_sums_q;

`ifdef XNORSEQ_THRESH_EN
  logic [M*SumL-1:0] thr_q;
  logic [M-1:0]      bits_cmp;
  logic [M-1:0]      out_bits_q;

  xnorseq_thresh #(
    .M   (M),
    .SumL(SumL)
  ) u_thresh (
    .sums(dp_sums),
    .thr (thr_q),
    .bits(bits_cmp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_q      <= '0;
      out_bits_q <= '0;
    end else begin
      if (accept)  thr_q      <= thr;
      if (capture) out_bits_q <= bits_cmp;
    end
  end

  assign out_bits = out_bits_q;
`else
  logic unused_thr;
  assign unused_thr = ^thr;
  assign out_bits   = '0;
`endif

endmodule

// File: doc/xnorseq_ctrl.md
# xnorseq_ctrl

Sequencing controller for the sequential XNOR-popcount layer (`xnorseqq`). Accepts one N-bit input vector over a valid/ready handshake, clears the datapath, and holds its `enable` high for a fixed number of accumulation cycles. It then captures the M popcount sums and presents them, optionally binarized against per-neuron thresholds, on a valid/ready output port. Sits between the upstream activation source and the next BNN layer; it is the only driver of the datapath's `data`, `rst` and `enable` pins.

## Interface
- `N`, 4, input vector width (matches datapath `N`)
- `M`, 4, neuron count (matches datapath `M`)
- `LAT`, 4, datapath enable cycles per vector; must be ≥1 (LAT=0 is an elaboration error)
- `SumL`, derived `$clog2(N+1)`, per-neuron sum width; not overridable
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input vector valid
- `in_ready`  out  1  controller can accept a vector
- `in_data`  in  N  input vector
- `thr`  in  M*SumL  per-neuron thresholds, neuron i at bits [i*SumL +: SumL]
- `dp_data`  out  N  registered vector to datapath `data`
- `dp_rst`  out  1  active-high clear to datapath `rst`
- `dp_enable`  out  1  to datapath `enable`
- `dp_sums`  in  M*SumL  datapath `sums`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_sums`  out  M*SumL  captured sums
- `out_bits`  out  M  binarized outputs
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE → CLEAR → RUN → CAPTURE → OUT → IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `in_data` into `dp_data` and `thr` into an internal threshold register, then go to CLEAR.
- CLEAR: one cycle with `dp_rst`=1. Go to RUN with run counter = 0.
- RUN: `dp_enable`=1 for exactly LAT cycles. The counter has width `$clog2(LAT+1)`. On reaching LAT−1, go to CAPTURE.
- CAPTURE: one cycle with `dp_enable`=0. At the end of the cycle, register `dp_sums` into `out_sums` and the threshold result into `out_bits`. Go to OUT.
- OUT: `out_valid`=1. `out_sums`/`out_bits` are held stable until `out_valid && out_ready`, then go to IDLE. `in_ready` is 0 in OUT, so there is no overlap.
- `dp_data` holds its value until the next accepted vector.
- Threshold: `out_bits[i]` = (sum_i ≥ thr_i), unsigned SumL-bit compare. thr_i=0 gives 1. thr_i > N gives 0.
- `dp_rst` = (~rst) | (state==CLEAR). The datapath is therefore held clear while the controller is in reset.
- Reset (asynchronous, any state): state IDLE, counter 0, `dp_data`=0, `out_sums`=0, `out_bits`=0, `out_valid`=0, `dp_enable`=0, `busy`=0. `in_ready` becomes 1 on the first cycle after deassertion. A mid-operation reset discards the in-flight vector with no output.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside OUT.

## Timing
- Acceptance edge = E0. CLEAR runs in cycle E0–E1. RUN covers E1…E(1+LAT). CAPTURE covers E(1+LAT)–E(2+LAT).
- `out_valid` rises at E(LAT+2): 6 edges for LAT=4.
- `out_ready` already high gives one OUT cycle, and the next vector can be accepted at E(LAT+4). Throughput is one vector per LAT+4 cycles.
- `in_ready`, `dp_rst` (apart from the reset term), `dp_enable`, `out_valid` and `busy` are decoded from registered state. No input-to-output combinational path exists.

## Configuration
- `XNORSEQ_THRESH_EN` defined: the threshold register and comparators are built, and `out_bits` behaves as specified above.
- Not defined: no threshold register or comparators are built. `thr` is ignored and `out_bits` is constant 0. `out_sums` and all timing are unchanged.

## Structure
- Package `xnorseq_pkg`: state enum (`IDLE`, `CLEAR`, `RUN`, `CAPTURE`, `OUT`) and function `suml(n)` = `$clog2(n+1)`, shared with the datapath and bench.
- Sub-module `xnorseq_thresh`: M parallel SumL-bit ≥ comparators (combinational). Instantiated only under `XNORSEQ_THRESH_EN`.

## Test plan
The bench uses a datapath stub that returns programmable sums.
- **Reset:** hold `rst`=0 for 3 cycles → all outputs 0, `dp_rst`=1. Release → `in_ready`=1, `dp_rst`=0.
- **Basic pass (N=M=4, LAT=4):** `in_data`=4'b1010, stub sums {3,0,4,2}, `thr`={2,1,4,3}, `out_ready`=1 → `dp_rst` high for 1 cycle, `dp_enable` high for exactly 4 cycles, `out_valid` at E6, `out_sums` = stub value, `out_bits`=4'b0101 (neuron 0 = bit 0).
- **Backpressure:** `out_ready`=0 for 10 cycles in OUT → outputs stable, `in_ready`=0, a second `in_valid` is not accepted. Raise `out_ready` → IDLE next cycle.
- **Threshold edges:** thr={0,5,4,4}, sums={0,4,4,3} → `out_bits`=4'b0101.
- **Mid-run reset:** assert `rst`=0 during the 2nd RUN cycle → `dp_enable`=0 immediately, no `out_valid` afterward. Next vector completes normally.
- **Macro off:** rebuild without `XNORSEQ_THRESH_EN` and rerun basic pass → same `out_sums` and timing, `out_bits`=0.
